cnu_sched: RTL
==============

# cnu_sched

Row scheduler for the check-node min-finder. It sweeps all check rows of the message memory for a programmed number of iterations, issuing one row read per cycle. Each row's D magnitudes are fed into an internal `cmpx` instance, and the row's min, min2 and one-hot min index are written back with the row address. It sits between the check-message RAM (1-cycle read latency, output held when not read) and the CNU result buffer.

## Interface
- `data_w`, 9: magnitude width per edge.
- `D`, 7: check-node degree; only 6 and 7 are legal.
- `ROWS`, 64: check rows per iteration; must be ≥ 2.
- `addr_w`, 6: row address width; 2^`addr_w` ≥ `ROWS`.
- `iter_w`, 5: iteration count width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  launch pulse; sampled only in IDLE.
- `n_iter`  in  `iter_w`  iterations to run; latched on accepted `start`.
- `abort`  in  1  stop at once; return to IDLE with no further writes.
- `hold`  in  1  freeze the whole pipeline this cycle (downstream not ready).
- `rd_en`  out  1  message RAM read strobe.
- `rd_addr`  out  `addr_w`  row being read.
- `rd_data`  in  `data_w*D`  RAM data, valid the cycle after `rd_en`.
- `wr_en`  out  1  result write strobe.
- `wr_addr`  out  `addr_w`  row of the result.
- `wr_min`, `wr_min2`  out  `data_w`  smallest and second-smallest magnitude.
- `wr_idx`  out  `D`  one-hot position of the minimum.
- `iter_done`  out  1  pulse with the write of row `ROWS`-1.
- `iter_cnt`  out  `iter_w`  index of the iteration currently being written.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start`=1 and `n_iter`≠0: latch `n_iter` and go to RUN with row=0, iteration=0.
  - `start`=1 and `n_iter`=0: go straight to DONE; no reads are issued.
- **RUN**
  - On each cycle with `hold`=0: assert `rd_en` with `rd_addr`=row, then increment row.
  - Row wraps from `ROWS`-1 to 0 and the read-iteration counter increments.
  - After the read of row `ROWS`-1 in the final iteration, go to DRAIN.
- **DRAIN**
  - No reads are issued.
  - Leave for DONE when both pipeline valid stages are empty and no write is pending this cycle.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- **Pipeline tags**
  - Stage 1 holds `v1` and `a1`; stage 2 holds `v2` and `a2`.
  - `cmpx` enable = `v1` & ~`hold`.
  - `wr_en` = `v2` & ~`hold`; `wr_addr` = `a2`; the result fields come directly from the `cmpx` registers.
- **hold=1**
  - `rd_en`, `cmp_en` and `wr_en` are all 0.
  - Row counter, tags and `cmpx` registers keep their values. The RAM holds its output.
- **abort**
  - Takes priority over `hold` and `start`.
  - Clears `v1` and `v2`, forces `rd_en` and `wr_en` to 0 in the same cycle, and goes to IDLE.
  - No `done` pulse is produced.
- **iter_cnt**
  - Increments after the write of row `ROWS`-1.
  - `iter_done` is asserted in the same cycle as that write.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `rd_en`, `wr_en`, `iter_done`, `done`, `busy` = 0.
  - `rd_addr`, `wr_addr`, `iter_cnt` = 0.
  - `wr_min`, `wr_min2`, `wr_idx` = 0, because the `cmpx` registers are reset.
  - `v1`, `v2` = 0.
- Latency: a read issued in cycle k is written in cycle k+2 when there is no hold. Each held cycle adds exactly 1.
- `start` accepted at edge 0, with no hold:
  - reads occur in cycles 1..N·`ROWS`;
  - writes occur in cycles 3..N·`ROWS`+2;
  - `done` is asserted in cycle N·`ROWS`+3.
- Iteration boundaries have no bubble. Row 0 of iteration i+1 is read in the cycle after row `ROWS`-1 of iteration i.
- Throughput: 1 row per non-held cycle.
- `rst` mid-run behaves like `abort`, and additionally restores every reset value.

## Structure
- Package `cnu_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - localparam `CMP_LAT`=1;
  - the legal-`D` check.
- Sub-module: the existing `cmpx`, instantiated once and parameterized with `data_w` and `D`.
- Counters, FSM and tag pipeline all live in `cnu_sched`.

## Test plan
- **Basic:** `ROWS`=4, `n_iter`=1, RAM row r holds {60,50,40,30,20,10,5+r} with `D`=7 → writes at cycles 3..6, addr 0..3, min=5+r, min2=10 for r≤4, `wr_idx`=7'b1000000, `done` at cycle 7.
- **Multi-iteration:** `n_iter`=3, `ROWS`=4 → 12 consecutive reads with no gap, `iter_done` at cycles 6, 10 and 14 with `iter_cnt` 0, 1 and 2, `done` at cycle 15.
- **Hold:** assert `hold` for 2 cycles at cycle 4 → no strobes during those cycles, each result still correct, every later event shifted by +2, `done` at cycle 9.
- **Zero iterations:** `start` with `n_iter`=0 → `done` next cycle, `rd_en` never asserted, `busy` high for 1 cycle.
- **Abort:** assert `abort` at cycle 4 of a 4-row run → `rd_en` and `wr_en` are 0 from cycle 4 on, IDLE at cycle 5, no `done`; a new `start` restarts at row 0.
- **Reset and ignored start:** `rst` mid-RUN → all outputs return to reset values on the next cycle. Separately, `start` pulsed during RUN is ignored, and the run count stays unchanged.

Source files
------------

// File: rtl/cnu_pkg.sv
// Shared types and constants for the check-node row scheduler.
// Holds the FSM state encoding, the comparator latency and the legal-degree test.
package cnu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam int CMP_LAT = 1;

   function automatic bit d_is_legal(input int d);
      return (d == 6) || (d == 7);
   endfunction

endpackage

// File: rtl/cmpx.sv
// Registered min / second-min finder over D packed magnitudes.
// Edge 0 is the most-significant slice; idx[k] marks edge k, and ties go to the lowest k.
module cmpx #(
   parameter int data_w = 9,
   parameter int D      = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [data_w*D-1:0] in_data,
   output logic [data_w-1:0]   min,
   output logic [data_w-1:0]   min2,
   output logic [D-1:0]        idx
);

   logic [data_w-1:0] m1_c;
   logic [data_w-1:0] m2_c;
   logic [data_w-1:0] x;
   logic [D-1:0]      idx_c;

   // Duplicated minima give min2 == min, since an equal value falls into the second slot
   always_comb begin
      m1_c  = in_data[data_w*D-1 -: data_w];
      m2_c  = '1;
      idx_c = '0;
      idx_c[0] = 1'b1;
      x     = '0;
      for (int k = 1; k < D; k++) begin
         x = in_data[data_w*(D-k)-1 -: data_w];
         if (x < m1_c) begin
            m2_c     = m1_c;
            m1_c     = x;
            idx_c    = '0;
            idx_c[k] = 1'b1;
         end else if (x < m2_c) begin
            m2_c = x;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min  <= '0;
         min2 <= '0;
         idx  <= '0;
      end else if (en) begin
         min  <= m1_c;
         min2 <= m2_c;
         idx  <= idx_c;
      end
   end

endmodule

// File: rtl/cnu_sched.sv
// Row scheduler: sweeps all check rows for n_iter iterations, one read per cycle,
// and writes each row's min / min2 / index two cycles later through a tagged pipeline.
module cnu_sched
   import cnu_pkg::*;
#(
   parameter int data_w = 9,
   parameter int D      = 7,
   parameter int ROWS   = 64,
   parameter int addr_w = 6,
   parameter int iter_w = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [iter_w-1:0]   n_iter,
   input  logic                abort,
   input  logic                hold,
   output logic                rd_en,
   output logic [addr_w-1:0]   rd_addr,
   input  logic [data_w*D-1:0] rd_data,
   output logic                wr_en,
   output logic [addr_w-1:0]   wr_addr,
   output logic [data_w-1:0]   wr_min,
   output logic [data_w-1:0]   wr_min2,
   output logic [D-1:0]        wr_idx,
   output logic                iter_done,
   output logic [iter_w-1:0]   iter_cnt,
   output logic                busy,
   output logic                done
);

   if (!d_is_legal(D) || (ROWS < 2) || ((2 ** addr_w) < ROWS) || (CMP_LAT != 1)) begin : g_param_check
      $error("cnu_sched: illegal parameterization");
   end

   state_t            state;
   state_t            state_nxt;
   logic [addr_w-1:0] row;
   logic [iter_w-1:0] rd_iter;
   logic [iter_w-1:0] n_iter_q;
   logic              v1;
   logic              v2;
   logic [addr_w-1:0] a1;
   logic [addr_w-1:0] a2;
   logic              cmp_en;
   logic              start_ok;
   logic              last_row;
   logic              last_iter;

   assign start_ok  = (state == IDLE) && start && !abort;
   assign last_row  = (row == addr_w'(ROWS - 1));
   assign last_iter = (rd_iter == (n_iter_q - iter_w'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // DRAIN may leave in the cycle that retires the last write, so done lands one cycle later
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = (n_iter != '0) ? RUN : DONE;
            RUN:     if (!hold && last_row && last_iter) state_nxt = DRAIN;
            DRAIN:   if (!v1 && !(v2 && hold)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      rd_en     = (state == RUN) && !hold && !abort;
      wr_en     = v2 && !hold && !abort;
      cmp_en    = v1 && !hold;
      iter_done = wr_en && (a2 == addr_w'(ROWS - 1));
      busy      = (state != IDLE);
      done      = (state == DONE);
   end

   assign rd_addr = row;
   assign wr_addr = a2;

   // Read-side row / iteration counters and the write-side iteration index
   always_ff @(posedge clk) begin
      if (rst) begin
         row      <= '0;
         rd_iter  <= '0;
         n_iter_q <= '0;
         iter_cnt <= '0;
      end else if (start_ok) begin
         row      <= '0;
         rd_iter  <= '0;
         n_iter_q <= n_iter;
         iter_cnt <= '0;
      end else begin
         if (rd_en) begin
            if (last_row) begin
               row     <= '0;
               rd_iter <= rd_iter + iter_w'(1);
            end else begin
               row <= row + addr_w'(1);
            end
         end
         if (iter_done) begin
            iter_cnt <= iter_cnt + iter_w'(1);
         end
      end
   end

   // Stage 1 tracks the RAM read in flight, stage 2 the comparator result awaiting write
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         a1 <= '0;
         a2 <= '0;
      end else if (abort) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else if (!hold) begin
         v1 <= rd_en;
         a1 <= row;
         v2 <= v1;
         a2 <= a1;
      end
   end

   cmpx #(
      .data_w (data_w),
      .D      (D)
   ) u_cmpx (
      .clk     (clk),
      .rst     (rst),
      .en      (cmp_en),
      .in_data (rd_data),
      .min     (wr_min),
      .min2    (wr_min2),
      .idx     (wr_idx)
   );

endmodule
